seg_display_scheduler: RTL and testbench
========================================

# seg_display_scheduler

Scan controller and arbiter for the 4-digit seven-segment display. It generates digit-scan timing from the single system clock, which replaces separate slow scan clocks. It shares the display between two 16-bit data sources using a req/gnt handshake with frame-aligned switching and a minimum hold time. It also inserts per-digit blanking to suppress ghosting. It sits between the counter/message producers and the board anode/segment pins.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range is ≥ BLANK_CYC+2.
- BLANK_CYC, 16: cycles at the start of each slot with segments forced off; legal range is ≥ 1.
- HOLD_FRAMES, 4: minimum frames a granted source keeps the display before it can be pre-empted by the other requester; legal range is ≥ 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_a  in  1  source A requests the display.
- data_a  in  16  source A value; nibble k shows on digit k.
- req_b  in  1  source B requests the display.
- data_b  in  16  source B value.
- gnt_a  out  1  source A owns the display.
- gnt_b  out  1  source B owns the display.
- anodes  out  4  one-hot, active-high digit select; bit k selects digit k.
- segments  out  7  active-high segments, bit0 = a … bit6 = g, decoded through data_to_seg.
- frame_done  out  1  one-cycle pulse on the last cycle of digit 3's slot.

## Operation
- **Prescaler:**
  - `pre` counts 0..SCAN_DIV-1 and wraps.
  - A slot tick occurs when `pre == SCAN_DIV-1`.
- **Digit index:**
  - `dig` is 2 bits and increments on each slot tick; 3 wraps to 0.
  - `anodes = 1 << dig`.
- **Frame:** a frame is slots 0..3. `frame_done` is high in the cycle where `pre == SCAN_DIV-1` and `dig == 3`.
- **Arbiter FSM** has three states: IDLE, OWN_A, OWN_B. It is evaluated only in `frame_done` cycles; the new state takes effect on the following edge.
  - **IDLE:**
    - req_a only → OWN_A.
    - req_b only → OWN_B.
    - Both → the source not granted last (`last` flag, reset value = B, so A wins first).
    - Neither → IDLE.
  - **OWN_x:**
    - req_x low → OWN_y if req_y is high, else IDLE.
    - req_x high, req_y high, and `hold >= HOLD_FRAMES-1` → OWN_y.
    - Otherwise stay in OWN_x and increment `hold`, saturating at HOLD_FRAMES-1.
  - `hold` clears on every state change.
- **Grants:** gnt_a = (state == OWN_A) and gnt_b = (state == OWN_B). They are never both high.
- **Mid-frame req changes:** deasserting req mid-frame does not drop the grant before the frame boundary.
- **Snapshot:** on the edge that starts a new frame, the 16-bit display register loads the data of the newly granted source, or 0 in IDLE. All four digits of a frame therefore come from one coherent value.
- **Segment output:**
  - Forced to 7'h00 when `pre < BLANK_CYC`.
  - Forced to 7'h00 while the FSM is IDLE.
  - Otherwise it is the decoded nibble `dig` of the snapshot.
- **Reset values:**

  | Signal / state | Reset value |
  |---|---|
  | pre, dig, hold | 0 |
  | anodes | 4'b0001 |
  | segments | 7'h00 |
  | gnt_a, gnt_b | 0 |
  | frame_done | 0 |
  | FSM state | IDLE |
  | snapshot | 0 |

  Reset asserted mid-frame returns all of the above immediately (asynchronously), with no glitch through a partial frame.

## Timing
- **Outputs:** anodes, segments, gnt_a and gnt_b are registered.
- **On the slot-tick edge:**
  - `anodes` moves to the next digit.
  - `segments` goes to 0 and stays 0 for BLANK_CYC cycles.
  - The decoded value appears on cycle BLANK_CYC of the slot and holds to the slot end.
- **On the edge after frame_done**, in the same cycle:
  - The grant changes.
  - The snapshot reloads.
  - `anodes` returns to 4'b0001.
- **Request-to-grant latency:** from IDLE, at most 4*SCAN_DIV cycles.
- **Pre-emption:** with both sources requesting, the owner keeps the display for exactly HOLD_FRAMES frames.
- **First frame after reset release:** `pre` starts at 0, so the first frame_done occurs at cycle 4*SCAN_DIV-1.

## Configuration
- **SEG_SCHED_BLANK_EN defined:** blanking behaves as above.
- **SEG_SCHED_BLANK_EN undefined:**
  - BLANK_CYC is ignored.
  - Segments show the decoded value from the first cycle of each slot; the IDLE blank still applies.
  - All other timing is unchanged.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2.
- **Reset:** release rst_n; both req low.
  - anodes = 0001, then 0010, 0100, 1000, 0001 every 8 cycles.
  - segments are 0 throughout.
  - frame_done pulses at cycle 31, 63, and so on.
- **Single requester:** req_a=1, data_a=16'h1234.
  - gnt_a rises on the edge after the first frame_done.
  - Digit 0 shows the "4" pattern from slot cycle 2.
  - Digits 1/2/3 show "3"/"2"/"1".
  - Slot cycles 0–1 are 0.
- **Contention:** req_a=req_b=1 from reset.
  - A is granted first and holds 2 frames, then B is granted for 2 frames.
  - Ownership alternates every 2 frames thereafter.
  - gnt_a & gnt_b is never 1.
- **Mid-frame drop and data change:** drop req_a mid-frame while changing data_a.
  - The displayed digits stay at the old snapshot until frame end.
  - The grant then goes to B if req_b=1, else IDLE with blank segments.
- **Asynchronous reset mid-frame:** assert rst_n low at slot 2, cycle 5.
  - Outputs go to their reset values asynchronously, before the next clk edge.
- **Blanking compiled out:** undefine SEG_SCHED_BLANK_EN and repeat the single-requester scenario.
  - The decoded value appears from slot cycle 0.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: digit-scan timing, two-source display arbiter with
// frame-aligned switching and minimum hold, plus per-slot segment blanking.
// Optional feature macro: SEG_SCHED_BLANK_EN (defined -> blank the first
// BLANK_CYC cycles of every slot; undefined -> no per-slot blanking).
module seg_display_scheduler #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        frame_done
);

  localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]  BLANK_END = PRE_W'(BLANK_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES - 1);

`ifdef SEG_SCHED_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic                last_a, last_a_nxt;  // 1: A was granted most recently
  logic [PRE_W-1:0]    pre, pre_nxt;
  logic [1:0]          dig, dig_nxt;
  logic [15:0]         snap, snap_nxt;
  logic [3:0]          nib_nxt;
  logic                slot_tick, frame_end, blank;
  logic [6:0]          seg_nxt;

  // Hex nibble to active-high segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] data_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: data_to_seg = 7'h3F;
      4'h1: data_to_seg = 7'h06;
      4'h2: data_to_seg = 7'h5B;
      4'h3: data_to_seg = 7'h4F;
      4'h4: data_to_seg = 7'h66;
      4'h5: data_to_seg = 7'h6D;
      4'h6: data_to_seg = 7'h7D;
      4'h7: data_to_seg = 7'h07;
      4'h8: data_to_seg = 7'h7F;
      4'h9: data_to_seg = 7'h6F;
      4'hA: data_to_seg = 7'h77;
      4'hB: data_to_seg = 7'h7C;
      4'hC: data_to_seg = 7'h39;
      4'hD: data_to_seg = 7'h5E;
      4'hE: data_to_seg = 7'h79;
      default: data_to_seg = 7'h71;
    endcase
  endfunction

  assign slot_tick = (pre == PRE_MAX);
  assign frame_end = slot_tick && (dig == 2'd3);

  // Prescaler and digit index advance.
  always_comb begin
    pre_nxt = slot_tick ? '0 : pre + PRE_W'(1);
    dig_nxt = slot_tick ? dig + 2'd1 : dig;
  end

  // Arbiter next state, evaluated only at the frame boundary.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold;
    last_a_nxt = last_a;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (req_a && (!req_b || !last_a)) state_nxt = OWN_A;
          else if (req_b)                   state_nxt = OWN_B;
        end
        OWN_A: begin
          if (!req_a)                           state_nxt = req_b ? OWN_B : IDLE;
          else if (req_b && (hold == HOLD_MAX)) state_nxt = OWN_B;
          else if (hold != HOLD_MAX)            hold_nxt  = hold + HOLD_W'(1);
        end
        OWN_B: begin
          if (!req_b)                           state_nxt = req_a ? OWN_A : IDLE;
          else if (req_a && (hold == HOLD_MAX)) state_nxt = OWN_A;
          else if (hold != HOLD_MAX)            hold_nxt  = hold + HOLD_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) hold_nxt = '0;
      if (state_nxt == OWN_A) last_a_nxt = 1'b1;
      if (state_nxt == OWN_B) last_a_nxt = 1'b0;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold   <= '0;
      last_a <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      last_a <= last_a_nxt;
    end
  end

  // Frame snapshot and segment value for the upcoming cycle.
  always_comb begin
    snap_nxt = snap;
    if (frame_end) begin
      case (state_nxt)
        OWN_A:   snap_nxt = data_a;
        OWN_B:   snap_nxt = data_b;
        default: snap_nxt = '0;
      endcase
    end
    nib_nxt = snap_nxt[{dig_nxt, 2'b00} +: 4];
    blank   = BLANK_ON && (pre_nxt < BLANK_END);
    seg_nxt = ((state_nxt == IDLE) || blank) ? 7'h00 : data_to_seg(nib_nxt);
  end

  // Scan counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      dig        <= '0;
      snap       <= '0;
      anodes     <= 4'b0001;
      segments   <= 7'h00;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pre        <= pre_nxt;
      dig        <= dig_nxt;
      snap       <= snap_nxt;
      anodes     <= 4'b0001 << dig_nxt;
      segments   <= seg_nxt;
      gnt_a      <= (state_nxt == OWN_A);
      gnt_b      <= (state_nxt == OWN_B);
      frame_done <= (pre_nxt == PRE_MAX) && (dig_nxt == 2'd3);
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler (SCAN_DIV=8, BLANK_CYC=2, HOLD_FRAMES=2).
// Expectations follow SEG_SCHED_BLANK_EN the same way the design does.
module tb_seg_display_scheduler;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int HF = 2;
`ifdef SEG_SCHED_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        gnt_a, gnt_b, frame_done;
  logic [3:0]  anodes;
  logic [6:0]  segments;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;  // rising edges since reset release

  seg_display_scheduler #(.SCAN_DIV(SD), .BLANK_CYC(BC), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .anodes(anodes), .segments(segments),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Hand-written segment codes for the digits used below.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'h3F;
      4'h1: seg_of = 7'h06;
      4'h2: seg_of = 7'h5B;
      4'h3: seg_of = 7'h4F;
      4'h4: seg_of = 7'h66;
      4'h5: seg_of = 7'h6D;
      4'h8: seg_of = 7'h7F;
      4'h9: seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] shown(input logic [15:0] v, input int kk);
    logic [15:0] t;
    int d, c;
    t = v;
    d = (kk / SD) % 4;
    c = kk % SD;
    if (BLANK && c < BC) shown = 7'h00;
    else                 shown = seg_of(t[d*4 +: 4]);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_reset(input logic ra, input logic rb,
                          input logic [15:0] da, input logic [15:0] db);
    @(negedge clk);
    rst_n  = 1'b0;
    req_a  = ra;
    req_b  = rb;
    data_a = da;
    data_b = db;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    logic both_seen;
    logic [3:0] exp_an;
    int f, own;

    // Reset state and idle scan
    #1 rst_n = 1'b0;
    #1;
    check("rst_anodes", 32'(anodes), 32'h1);
    check("rst_segments", 32'(segments), 32'h0);
    check("rst_gnt", 32'({gnt_a, gnt_b}), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    do_reset(1'b0, 1'b0, 16'h0, 16'h0);
    check("idle_anodes_k0", 32'(anodes), 32'h1);
    for (int i = 1; i <= 64; i++) begin
      tick();
      exp_an = 4'b0001 << ((k / SD) % 4);
      check("idle_anodes", 32'(anodes), 32'(exp_an));
      check("idle_segments", 32'(segments), 32'h0);
      check("idle_frame_done", 32'(frame_done), 32'((k % 32) == 31));
    end

    // Single requester A with 0x1234
    do_reset(1'b1, 1'b0, 16'h1234, 16'h0);
    for (int i = 1; i <= 64; i++) begin
      tick();
      check("single_gnt_a", 32'(gnt_a), 32'(k >= 32));
      check("single_gnt_b", 32'(gnt_b), 32'h0);
      check("single_segments", 32'(segments), (k >= 32) ? 32'(shown(16'h1234, k)) : 32'h0);
      if (k == 32) check("single_anodes_wrap", 32'(anodes), 32'h1);
      if (k % 32 == 31) check("single_frame_done", 32'(frame_done), 32'h1);
    end

    // Contention: A=0x0000, B=0x8888, both requesting from reset
    do_reset(1'b1, 1'b1, 16'h0000, 16'h8888);
    both_seen = 1'b0;
    for (int i = 1; i < 32 * 9; i++) begin
      tick();
      if (gnt_a && gnt_b) both_seen = 1'b1;
      if (k % 32 == 3) begin
        f = k / 32;
        own = (f == 0) ? 0 : ((((f - 1) / 2) % 2) == 0 ? 1 : 2);
        check($sformatf("cont_gnt_a_f%0d", f), 32'(gnt_a), 32'(own == 1));
        check($sformatf("cont_gnt_b_f%0d", f), 32'(gnt_b), 32'(own == 2));
        check($sformatf("cont_seg_f%0d", f), 32'(segments),
              (own == 1) ? 32'h3F : (own == 2) ? 32'h7F : 32'h0);
      end
    end
    check("cont_never_both", 32'(both_seen), 32'h0);

    // Mid-frame drop of req_a with data change, B not requesting -> IDLE
    do_reset(1'b1, 1'b0, 16'h1234, 16'h0);
    run_to(44);
    req_a  = 1'b0;
    data_a = 16'h5678;
    for (int i = 45; i <= 72; i++) begin
      tick();
      if (k < 64) begin
        check("drop_hold_gnt", 32'(gnt_a), 32'h1);
        check("drop_old_seg", 32'(segments), 32'(shown(16'h1234, k)));
      end else begin
        check("drop_idle_gnt", 32'({gnt_a, gnt_b}), 32'h0);
        check("drop_idle_seg", 32'(segments), 32'h0);
      end
    end

    // Mid-frame drop of req_a with B requesting -> B takes over
    do_reset(1'b1, 1'b1, 16'h1234, 16'h9999);
    run_to(44);
    req_a  = 1'b0;
    data_a = 16'h5678;
    for (int i = 45; i <= 72; i++) begin
      tick();
      if (k < 64) begin
        check("dropb_hold_gnt", 32'({gnt_a, gnt_b}), 32'h2);
        check("dropb_old_seg", 32'(segments), 32'(shown(16'h1234, k)));
      end else begin
        check("dropb_gnt_b", 32'({gnt_a, gnt_b}), 32'h1);
        check("dropb_seg", 32'(segments), 32'(shown(16'h9999, k)));
      end
    end

    // Asynchronous reset at frame 1, slot 2, cycle 5
    do_reset(1'b1, 1'b0, 16'h1234, 16'h0);
    run_to(32 + 2 * SD + 5);
    check("arst_pre_gnt", 32'(gnt_a), 32'h1);
    check("arst_pre_anodes", 32'(anodes), 32'h4);
    check("arst_pre_seg", 32'(segments), 32'h5B);
    #2 rst_n = 1'b0;
    #1;
    check("arst_anodes", 32'(anodes), 32'h1);
    check("arst_segments", 32'(segments), 32'h0);
    check("arst_gnt", 32'({gnt_a, gnt_b}), 32'h0);
    check("arst_frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
